// File: rtl/two_way_true_demux_if.sv
// Handshake bundle for the buffered 1-to-2 word demultiplexer.
// The producer side and both consumer sides share one interface; master is the
// environment (producer + consumers), slave is the demux itself.
interface two_way_true_demux_if #(
    parameter int unsigned WIDTH       = 17,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic [WIDTH-1:0]       Input1;
    logic                   Selection;
    logic                   InValid;
    logic                   InReady;
    logic [WIDTH-1:0]       Output1;
    logic [WIDTH-1:0]       Output2;
    logic                   Out1Valid;
    logic                   Out2Valid;
    logic                   Out1Ready;
    logic                   Out2Ready;
    logic [COUNT_WIDTH-1:0] Count1;
    logic [COUNT_WIDTH-1:0] Count2;

    modport master (
        output Input1, Selection, InValid, Out1Ready, Out2Ready,
        input  InReady, Output1, Output2, Out1Valid, Out2Valid, Count1, Count2
    );

    modport slave (
        input  Input1, Selection, InValid, Out1Ready, Out2Ready,
        output InReady, Output1, Output2, Out1Valid, Out2Valid, Count1, Count2
    );
endinterface

// File: rtl/two_way_true_demux.sv
// Buffered 1-to-2 word demultiplexer: each accepted word is steered by
// Selection into one of two circular FIFOs, each drained by its own
// valid/ready consumer, with a wrapping delivered-word counter per side.
// Index 0 of every per-side array is output 1, index 1 is output 2.
module two_way_true_demux #(
    parameter int unsigned WIDTH       = 17,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input logic                Clock,
    input logic                Reset,
    two_way_true_demux_if.slave bus
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       OCC_W    = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);

    logic [WIDTH-1:0]       mem_q    [2][DEPTH];
    logic [WIDTH-1:0]       mem_d    [2][DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [2];
    logic [PTR_W-1:0]       wr_ptr_d [2];
    logic [PTR_W-1:0]       rd_ptr_q [2];
    logic [PTR_W-1:0]       rd_ptr_d [2];
    logic [OCC_W-1:0]       occ_q    [2];
    logic [OCC_W-1:0]       occ_d    [2];
    logic [COUNT_WIDTH-1:0] cnt_q    [2];
    logic [COUNT_WIDTH-1:0] cnt_d    [2];

    logic [1:0]             full;
    logic [1:0]             valid;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             out_ready;
    logic                   in_ready;
    logic [WIDTH-1:0]       head     [2];

    // Acceptance depends only on the selected buffer's occupancy, so a pop on
    // the same edge frees the slot for the following cycle, never this one.
    always_comb begin
        out_ready = {bus.Out2Ready, bus.Out1Ready};
        for (int unsigned k = 0; k < 2; k++) begin
            full[k]  = (occ_q[k] == OCC_FULL);
            valid[k] = (occ_q[k] != '0);
            pop[k]   = valid[k] && out_ready[k];
        end
        in_ready = bus.Selection ? !full[1] : !full[0];
        push[0]  = bus.InValid && in_ready && !bus.Selection;
        push[1]  = bus.InValid && in_ready &&  bus.Selection;
    end

    // Per-side FIFO next state: write at wr_ptr, read at rd_ptr, occupancy
    // tracks push/pop so full and empty stay distinguishable.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        for (int unsigned k = 0; k < 2; k++) begin
            head[k] = valid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = bus.Input1;
                wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
                cnt_d[k]    = cnt_q[k] + COUNT_WIDTH'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + OCC_W'(1);
                2'b01:   occ_d[k] = occ_q[k] - OCC_W'(1);
                default: occ_d[k] = occ_q[k];
            endcase
        end
    end

    // State registers; reset discards all buffered words and clears counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned k = 0; k < 2; k++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.Output1   = head[0];
    assign bus.Output2   = head[1];
    assign bus.Out1Valid = valid[0];
    assign bus.Out2Valid = valid[1];
    assign bus.Count1    = cnt_q[0];
    assign bus.Count2    = cnt_q[1];

endmodule

// File: tb/tb_two_way_true_demux.sv
// Directed bench for two_way_true_demux: a cycle-by-cycle vector table
// (inputs plus expected pre-edge outputs) followed by hand-written sequences
// for asynchronous reset mid-operation and counter wrap.
// Counters are instantiated 8 bits wide so the wrap case stays short.
module tb_two_way_true_demux;

    localparam int unsigned W  = 17;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    two_way_true_demux_if #(.WIDTH(W), .COUNT_WIDTH(CW)) bus ();

    two_way_true_demux #(.WIDTH(W), .DEPTH(2), .COUNT_WIDTH(CW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic          iv;
        logic [W-1:0]  din;
        logic          r1;
        logic          r2;
        logic          rdy;
        logic          v1;
        logic [W-1:0]  o1;
        logic          v2;
        logic [W-1:0]  o2;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sel, input logic iv, input logic [W-1:0] din,
                       input logic r1, input logic r2, input logic rdy,
                       input logic v1, input logic [W-1:0] o1,
                       input logic v2, input logic [W-1:0] o2,
                       input logic [CW-1:0] c1, input logic [CW-1:0] c2);
        vec_t v;
        v.sel = sel; v.iv = iv; v.din = din; v.r1 = r1; v.r2 = r2;
        v.rdy = rdy; v.v1 = v1; v.o1 = o1; v.v2 = v2; v.o2 = o2;
        v.c1 = c1; v.c2 = c2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sel, input logic iv, input logic [W-1:0] din,
                         input logic r1, input logic r2);
        bus.Selection = sel;
        bus.InValid   = iv;
        bus.Input1    = din;
        bus.Out1Ready = r1;
        bus.Out2Ready = r2;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic v1,
                           input logic [W-1:0] o1, input logic v2, input logic [W-1:0] o2,
                           input logic [CW-1:0] c1, input logic [CW-1:0] c2);
        chk({tag, ".InReady"},   32'(bus.InReady),   32'(rdy));
        chk({tag, ".Out1Valid"}, 32'(bus.Out1Valid), 32'(v1));
        chk({tag, ".Output1"},   32'(bus.Output1),   32'(o1));
        chk({tag, ".Out2Valid"}, 32'(bus.Out2Valid), 32'(v2));
        chk({tag, ".Output2"},   32'(bus.Output2),   32'(o2));
        chk({tag, ".Count1"},    32'(bus.Count1),    32'(c1));
        chk({tag, ".Count2"},    32'(bus.Count2),    32'(c2));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: sel iv din r1 r2 | InReady v1 o1 v2 o2 c1 c2 (before the edge)
        // single word to side 1
        add(0, 1, 17'h1ABCD, 1, 0,  1, 0, 17'h00000, 0, 17'h00000, 0, 0);
        add(0, 0, 17'h00000, 1, 0,  1, 1, 17'h1ABCD, 0, 17'h00000, 0, 0);
        // fill side 2 while stalled
        add(1, 1, 17'h00001, 0, 0,  1, 0, 17'h00000, 0, 17'h00000, 1, 0);
        add(1, 1, 17'h00002, 0, 0,  1, 0, 17'h00000, 1, 17'h00001, 1, 0);
        add(1, 1, 17'h00003, 0, 0,  0, 0, 17'h00000, 1, 17'h00001, 1, 0);
        add(0, 0, 17'h00003, 0, 0,  1, 0, 17'h00000, 1, 17'h00001, 1, 0);
        add(1, 1, 17'h00003, 0, 1,  0, 0, 17'h00000, 1, 17'h00001, 1, 0);
        add(1, 0, 17'h00000, 0, 1,  1, 0, 17'h00000, 1, 17'h00002, 1, 1);
        add(0, 0, 17'h00000, 1, 1,  1, 0, 17'h00000, 0, 17'h00000, 1, 2);
        // alternating selection, both consumers ready
        add(0, 1, 17'h00100, 1, 1,  1, 0, 17'h00000, 0, 17'h00000, 1, 2);
        add(1, 1, 17'h00101, 1, 1,  1, 1, 17'h00100, 0, 17'h00000, 1, 2);
        add(0, 1, 17'h00102, 1, 1,  1, 0, 17'h00000, 1, 17'h00101, 2, 2);
        add(1, 1, 17'h00103, 1, 1,  1, 1, 17'h00102, 0, 17'h00000, 2, 3);
        add(0, 1, 17'h00104, 1, 1,  1, 0, 17'h00000, 1, 17'h00103, 3, 3);
        add(1, 1, 17'h00105, 1, 1,  1, 1, 17'h00104, 0, 17'h00000, 3, 4);
        add(0, 1, 17'h00106, 1, 1,  1, 0, 17'h00000, 1, 17'h00105, 4, 4);
        add(1, 1, 17'h00107, 1, 1,  1, 1, 17'h00106, 0, 17'h00000, 4, 5);
        add(0, 0, 17'h00000, 1, 1,  1, 0, 17'h00000, 1, 17'h00107, 5, 5);
        add(0, 0, 17'h00000, 1, 1,  1, 0, 17'h00000, 0, 17'h00000, 5, 6);
        // side 1 at DEPTH-1: push+pop, then full, then pop frees a slot
        add(0, 1, 17'h00AAA, 0, 0,  1, 0, 17'h00000, 0, 17'h00000, 5, 6);
        add(0, 1, 17'h00BBB, 1, 0,  1, 1, 17'h00AAA, 0, 17'h00000, 5, 6);
        add(0, 1, 17'h00CCC, 0, 0,  1, 1, 17'h00BBB, 0, 17'h00000, 6, 6);
        add(0, 1, 17'h00DDD, 1, 0,  0, 1, 17'h00BBB, 0, 17'h00000, 6, 6);
        add(0, 0, 17'h00000, 0, 0,  1, 1, 17'h00CCC, 0, 17'h00000, 7, 6);
        add(0, 0, 17'h00000, 1, 0,  1, 1, 17'h00CCC, 0, 17'h00000, 7, 6);
        add(0, 0, 17'h00000, 0, 0,  1, 0, 17'h00000, 0, 17'h00000, 8, 6);

        drive(0, 0, '0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 1, 0, '0, 0, '0, '0, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sel, vecs[i].iv, vecs[i].din, vecs[i].r1, vecs[i].r2);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].v1, vecs[i].o1,
                    vecs[i].v2, vecs[i].o2, vecs[i].c1, vecs[i].c2);
            @(negedge clk);
        end

        // Asynchronous reset between edges with both buffers occupied
        drive(0, 1, 17'h15555, 0, 0); @(negedge clk);
        drive(0, 1, 17'h0AAAA, 0, 0); @(negedge clk);
        drive(1, 1, 17'h13333, 0, 0); @(negedge clk);
        drive(0, 0, '0, 0, 0);
        #1;
        chk_all("preload", 0, 1, 17'h15555, 1, 17'h13333, 8, 6);
        #1;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1, 0, '0, 0, '0, '0, '0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("post_rst%0d", i), 1, 0, '0, 0, '0, '0, '0);
        end

        // Counter wrap: 255 words through side 1, then one more pops to 0
        for (int i = 0; i < 255; i++) begin
            drive(0, 1, W'(i), 1, 0);
            @(negedge clk);
        end
        drive(0, 0, '0, 1, 0);
        @(negedge clk);
        #1;
        chk_all("pre_wrap", 1, 0, '0, 0, '0, 8'hFF, '0);
        drive(0, 1, 17'h1FFFF, 0, 0);
        @(negedge clk);
        drive(0, 0, '0, 1, 0);
        #1;
        chk_all("wrap_head", 1, 1, 17'h1FFFF, 0, '0, 8'hFF, '0);
        @(negedge clk);
        #1;
        chk_all("wrap", 1, 0, '0, 0, '0, 8'h00, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
